// File: rtl/btb_maint_ctrl.sv
// BTB write-port owner: post-reset clear walk, multi-cycle flush walk, and branch updates (replayed from a FIFO after a walk).
// One cycle from decision to registered RAM write; updates are never backpressured and are dropped with overflow_o when the FIFO is full.
module btb_maint_ctrl #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned NR_ROWS         = 8,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          RVC             = 1'b1,
  parameter int unsigned UPD_FIFO_DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic [VLEN-1:0]            upd_target_i,
  output logic                       ram_we_o,
  output logic [$clog2(NR_ROWS)-1:0] ram_addr_o,
  output logic [INSTR_PER_FETCH-1:0] ram_be_o,
  output logic                       ram_wvalid_o,
  output logic [VLEN-1:0]            ram_wtarget_o,
  output logic                       busy_o,
  output logic                       overflow_o
);

  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_W         = $clog2(NR_ROWS);
  localparam int unsigned COL_W         = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int unsigned AW            = $clog2(UPD_FIFO_DEPTH);
  localparam int unsigned PW            = AW + 1;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [VLEN-1:0]  target;
  } upd_t;

  typedef enum logic [1:0] {CLEAR, IDLE, FLUSH} state_e;

  state_e state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  upd_t fifo_mem [UPD_FIFO_DEPTH];

  logic                       we_q, we_d;
  logic [ROW_W-1:0]           addr_q, addr_d;
  logic [INSTR_PER_FETCH-1:0] be_q, be_d;
  logic                       wvalid_q, wvalid_d;
  logic [VLEN-1:0]            wtarget_q, wtarget_d;
  logic                       busy_q, busy_d;
  logic                       ovf_q, ovf_d;

  upd_t upd_in, head, wr_upd;
  logic accept, empty, full, push, issue_upd;
  logic unused_pc;

  assign unused_pc = ^upd_pc_i;
  assign accept    = upd_valid_i && !debug_mode_i;
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head      = fifo_mem[rptr_q[AW-1:0]];

  always_comb begin
    upd_in        = '0;
    upd_in.row    = upd_pc_i[OFFSET+ROW_ADDR_BITS +: ROW_W];
    upd_in.col    = (RVC && ROW_ADDR_BITS > 0) ? upd_pc_i[OFFSET +: COL_W] : '0;
    upd_in.target = upd_target_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    we_d      = 1'b0;
    addr_d    = '0;
    be_d      = '0;
    wvalid_d  = 1'b0;
    wtarget_d = '0;
    ovf_d     = 1'b0;
    push      = 1'b0;
    issue_upd = 1'b0;
    wr_upd    = upd_in;

    if (flush_bp_i) begin
      // Flush discards both the buffer and any same-cycle update, and issues no write.
      state_d = FLUSH;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      unique case (state_q)
        CLEAR, FLUSH: begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          be_d   = '1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == ROW_W'(NR_ROWS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
          push  = accept && !full;
          ovf_d = accept && full;
        end
        IDLE: begin
          if (!empty) begin
            issue_upd = 1'b1;
            wr_upd    = head;
            rptr_d    = rptr_q + PW'(1);
            push      = accept && !full;
            ovf_d     = accept && full;
          end else if (accept) begin
            issue_upd = 1'b1;
          end
        end
        default: state_d = CLEAR;
      endcase
      if (push) wptr_d = wptr_q + PW'(1);
    end

    if (issue_upd) begin
      we_d      = 1'b1;
      addr_d    = wr_upd.row;
      be_d      = INSTR_PER_FETCH'(1) << wr_upd.col;
      wvalid_d  = 1'b1;
      wtarget_d = wr_upd.target;
    end

    // Held high through the cycle that shows the last walk write.
    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wvalid_q  <= 1'b0;
      wtarget_q <= '0;
      busy_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wvalid_q  <= wvalid_d;
      wtarget_q <= wtarget_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q[AW-1:0]] <= upd_in;
  end

  assign ram_we_o      = we_q;
  assign ram_addr_o    = addr_q;
  assign ram_be_o      = be_q;
  assign ram_wvalid_o  = wvalid_q;
  assign ram_wtarget_o = wtarget_q;
  assign busy_o        = busy_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_btb_maint_ctrl.sv
// Randomized plus directed bench for btb_maint_ctrl against a queue-based reference model.
module tb_btb_maint_ctrl;

  localparam int VLEN  = 64;
  localparam int NR    = 8;
  localparam int IPF   = 2;
  localparam int OFF   = 1;
  localparam int RB    = 1;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_bp_i, debug_mode_i, upd_valid_i;
  logic [VLEN-1:0] upd_pc_i, upd_target_i;
  logic            ram_we_o, ram_wvalid_o, busy_o, overflow_o;
  logic [2:0]      ram_addr_o;
  logic [IPF-1:0]  ram_be_o;
  logic [VLEN-1:0] ram_wtarget_o;

  btb_maint_ctrl #(
    .VLEN(VLEN), .NR_ROWS(NR), .INSTR_PER_FETCH(IPF), .RVC(1'b1), .UPD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
    .ram_wvalid_o(ram_wvalid_o), .ram_wtarget_o(ram_wtarget_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a walk is "rows left to write", pending updates are a queue.
  typedef struct {
    int          row;
    int          col;
    logic [63:0] tgt;
  } ent_t;

  ent_t        q[$];
  bit          m_walk;
  int          m_row;
  bit          e_we, e_wv, e_busy, e_ovf;
  int          e_addr, e_be;
  logic [63:0] e_tgt;

  function automatic ent_t mk(input logic [63:0] pc, input logic [63:0] tgt);
    ent_t e;
    e.row = int'((pc >> (OFF + RB)) % NR);
    e.col = int'((pc >> OFF) % IPF);
    e.tgt = tgt;
    return e;
  endfunction

  task automatic m_reset();
    q.delete();
    m_walk = 1; m_row = 0;
    e_we = 0; e_wv = 0; e_addr = 0; e_be = 0; e_tgt = 0; e_busy = 1; e_ovf = 0;
  endtask

  task automatic m_write_upd(input ent_t e);
    e_we = 1; e_addr = e.row; e_be = 1 << e.col; e_wv = 1; e_tgt = e.tgt;
  endtask

  task automatic m_tick();
    bit acc, was, full;
    ent_t in_e;
    acc  = upd_valid_i && !debug_mode_i;
    in_e = mk(upd_pc_i, upd_target_i);
    full = (q.size() == DEPTH);
    was  = m_walk;
    e_we = 0; e_ovf = 0;
    if (flush_bp_i) begin
      q.delete();
      m_walk = 1; m_row = 0; e_busy = 1;
    end else begin
      if (m_walk) begin
        e_we = 1; e_addr = m_row; e_be = (1 << IPF) - 1; e_wv = 0; e_tgt = 0;
        m_row++;
        if (m_row == NR) begin m_walk = 0; m_row = 0; end
        if (acc) begin if (full) e_ovf = 1; else q.push_back(in_e); end
      end else if (q.size() > 0) begin
        m_write_upd(q.pop_front());
        if (acc) begin if (full) e_ovf = 1; else q.push_back(in_e); end
      end else if (acc) begin
        m_write_upd(in_e);
      end
      e_busy = was || m_walk;
    end
  endtask

  task automatic compare(input bit all);
    chk("we", ram_we_o, e_we);
    chk("busy", busy_o, e_busy);
    chk("overflow", overflow_o, e_ovf);
    if (e_we || all) begin
      chk("addr", ram_addr_o, e_addr);
      chk("be", ram_be_o, e_be);
      chk("wvalid", ram_wvalid_o, e_wv);
      chk("wtarget", ram_wtarget_o, e_tgt);
    end
  endtask

  int wr_count, ovf_count;

  task automatic step(input logic f, input logic d, input logic v,
                      input logic [63:0] pc, input logic [63:0] tgt);
    flush_bp_i = f; debug_mode_i = d; upd_valid_i = v; upd_pc_i = pc; upd_target_i = tgt;
    @(posedge clk_i);
    m_tick();
    #1;
    compare(1'b0);
    if (ram_we_o && ram_wvalid_o) wr_count++;
    if (overflow_o) ovf_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_reset();
    #1;
    compare(1'b1);
    @(posedge clk_i);
    #1;
    compare(1'b1);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; flush_bp_i = 0; debug_mode_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_target_i = 0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare(1'b1);
    rst_ni = 1'b1;

    // Reset clear walk: rows 0..7 then idle.
    idle(11);

    // Direct update in idle, 1-cycle latency.
    step(0, 0, 1, 64'h26, 64'h1000);
    chk("direct_addr", ram_addr_o, 1);
    chk("direct_be", ram_be_o, 2'b10);
    chk("direct_tgt", ram_wtarget_o, 64'h1000);
    idle(2);

    // Three updates buffered during a flush, replayed in order.
    wr_count = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 64'h04, 64'hA0);
    step(0, 0, 1, 64'h08, 64'hA1);
    step(0, 0, 1, 64'h0C, 64'hA2);
    idle(12);
    chk("replay_count", wr_count, 3);

    // Overflow: five updates into a four-deep buffer.
    wr_count = 0; ovf_count = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 64'h10 + 64'(4 * i), 64'hB0 + 64'(i));
    idle(14);
    chk("ovf_pulses", ovf_count, 1);
    chk("ovf_replayed", wr_count, 4);

    // Flush restart mid-walk, with a colliding update.
    wr_count = 0;
    step(1, 0, 0, 0, 0);
    idle(6);
    step(1, 0, 1, 64'h30, 64'hC0);
    idle(12);
    chk("collide_written", wr_count, 0);

    // Debug gate.
    step(0, 1, 1, 64'h06, 64'hD0);
    chk("debug_no_we", ram_we_o, 0);
    idle(2);

    // Reset mid-flush with queued updates.
    wr_count = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 64'h14, 64'hE0);
    step(0, 0, 1, 64'h18, 64'hE1);
    idle(3);
    do_reset();
    idle(12);
    chk("reset_drop", wr_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 4, 64'($urandom_range(0, 255)),
             {32'($urandom), 32'($urandom)});
      end
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
